elevator_ctrl_n: RTL and testbench

//  Parametrised N-floor elevator controller: latches hall and car calls and serves them collectively,

---
 rtl/elevator_ctrl_n.sv | 173 +++++++++++++++++
 tb/tb_elevator_ctrl_n.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/elevator_ctrl_n.sv
// Collective N-floor elevator controller: latches hall/car calls and keeps moving while calls remain ahead.
// Optional door auto-close after a dwell period when DOOR_TIMEOUT_EN is defined.
module elevator_ctrl_n #(
  parameter int NUM_FLOORS   = 3,
  parameter int FS_W         = 2,
  parameter int DWELL_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] hall_up,
  input  logic [NUM_FLOORS-1:0] hall_dn,
  input  logic [NUM_FLOORS-1:0] car,
  input  logic [FS_W-1:0]       fs,
  input  logic                  dc,
  output logic                  door,
  output logic [1:0]            dir,
  output logic [FS_W-1:0]       cur_floor,
  output logic [1:0]            state,
  output logic [NUM_FLOORS-1:0] req_lamp
);

  typedef enum logic [1:0] {
    CLOSING = 2'b00,
    OPENED  = 2'b01,
    MOVE_UP = 2'b10,
    MOVE_DN = 2'b11
  } state_e;

  localparam logic [FS_W-1:0]       TOP     = FS_W'(NUM_FLOORS);
  // No up call exists at the top floor and no down call at the bottom floor.
  localparam logic [NUM_FLOORS-1:0] UP_MASK = {1'b0, {(NUM_FLOORS-1){1'b1}}};
  localparam logic [NUM_FLOORS-1:0] DN_MASK = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

  if (NUM_FLOORS < 2 || DWELL_CYCLES < 1 || (1 << FS_W) <= NUM_FLOORS) begin : g_bad_param
    $error("elevator_ctrl_n: illegal parameter combination");
  end

  function automatic logic [NUM_FLOORS-1:0] floor_oh(input logic [FS_W-1:0] f);
    floor_oh = '0;
    for (int i = 0; i < NUM_FLOORS; i++) floor_oh[i] = (f == FS_W'(i + 1));
  endfunction

  function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [FS_W-1:0] f);
    above_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) above_mask[i] = (FS_W'(i + 1) > f);
  endfunction

  function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [FS_W-1:0] f);
    below_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) below_mask[i] = (FS_W'(i + 1) < f);
  endfunction

  state_e                  state_q, state_d;
  logic [FS_W-1:0]         cur_floor_q, cur_floor_d;
  logic                    last_up_q, last_up_d;
  logic                    door_q, door_d;
  logic [1:0]              dir_q, dir_d;
  logic [NUM_FLOORS-1:0]   req_up_q, req_up_d, req_dn_q, req_dn_d, req_car_q, req_car_d;
  logic [NUM_FLOORS-1:0]   nxt_up, nxt_dn, nxt_car, nxt_all, btn_all, cur_oh, open_oh;
  logic                    fs_valid, press_here;
`ifdef DOOR_TIMEOUT_EN
  localparam int DW_W = $clog2(DWELL_CYCLES + 1);
  logic [DW_W-1:0]         dwell_q, dwell_d;
`endif

  always_comb begin
    btn_all     = (hall_up & UP_MASK) | (hall_dn & DN_MASK) | car;
    nxt_up      = req_up_q | (hall_up & UP_MASK);
    nxt_dn      = req_dn_q | (hall_dn & DN_MASK);
    nxt_car     = req_car_q | car;
    nxt_all     = nxt_up | nxt_dn | nxt_car;
    cur_oh      = floor_oh(cur_floor_q);
    press_here  = |(btn_all & cur_oh);
    fs_valid    = (fs != '0) && (fs <= TOP);
    state_d     = state_q;
    cur_floor_d = cur_floor_q;
    last_up_d   = last_up_q;

    unique case (state_q)
      CLOSING: begin
        // A call at the current floor reopens regardless of the door sensor.
        if (|(nxt_all & cur_oh)) begin
          state_d = OPENED;
        end else if (dc) begin
          if (last_up_q && |(nxt_all & above_mask(cur_floor_q))) begin
            state_d = MOVE_UP;
          end else if (!last_up_q && |(nxt_all & below_mask(cur_floor_q))) begin
            state_d = MOVE_DN;
          end else if (last_up_q && |(nxt_all & below_mask(cur_floor_q))) begin
            state_d   = MOVE_DN;
            last_up_d = 1'b0;
          end else if (!last_up_q && |(nxt_all & above_mask(cur_floor_q))) begin
            state_d   = MOVE_UP;
            last_up_d = 1'b1;
          end
        end
      end
      OPENED: begin
        if (|(nxt_all & ~cur_oh)) begin
          state_d = CLOSING;
`ifdef DOOR_TIMEOUT_EN
        end else if (!press_here && dwell_q == DW_W'(DWELL_CYCLES - 1)) begin
          state_d = CLOSING;
`endif
        end
      end
      MOVE_UP: begin
        if (fs_valid && fs > cur_floor_q) begin
          cur_floor_d = fs;
          if (|((nxt_car | nxt_up) & floor_oh(fs)) || !(|(nxt_all & above_mask(fs))))
            state_d = OPENED;
        end
      end
      MOVE_DN: begin
        if (fs_valid && fs < cur_floor_q) begin
          cur_floor_d = fs;
          if (|((nxt_car | nxt_dn) & floor_oh(fs)) || !(|(nxt_all & below_mask(fs))))
            state_d = OPENED;
        end
      end
      default: state_d = CLOSING;
    endcase

    // Calls at the floor where the doors are open are served, never latched.
    open_oh   = (state_d == OPENED) ? floor_oh(cur_floor_d) : '0;
    req_up_d  = nxt_up & ~open_oh;
    req_dn_d  = nxt_dn & ~open_oh;
    req_car_d = nxt_car & ~open_oh;

    door_d = (state_d != OPENED);
    dir_d  = (state_d == MOVE_UP) ? 2'b01 : (state_d == MOVE_DN) ? 2'b10 : 2'b00;

`ifdef DOOR_TIMEOUT_EN
    if (state_q != OPENED || state_d != OPENED || press_here) dwell_d = '0;
    else                                                      dwell_d = dwell_q + 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLOSING;
      cur_floor_q <= FS_W'(1);
      last_up_q   <= 1'b1;
      door_q      <= 1'b1;
      dir_q       <= 2'b00;
      req_up_q    <= '0;
      req_dn_q    <= '0;
      req_car_q   <= '0;
`ifdef DOOR_TIMEOUT_EN
      dwell_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cur_floor_q <= cur_floor_d;
      last_up_q   <= last_up_d;
      door_q      <= door_d;
      dir_q       <= dir_d;
      req_up_q    <= req_up_d;
      req_dn_q    <= req_dn_d;
      req_car_q   <= req_car_d;
`ifdef DOOR_TIMEOUT_EN
      dwell_q     <= dwell_d;
`endif
    end
  end

  assign door      = door_q;
  assign dir       = dir_q;
  assign cur_floor = cur_floor_q;
  assign state     = state_q;
  assign req_lamp  = req_up_q | req_dn_q | req_car_q;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Directed-vector bench for elevator_ctrl_n: a 3-floor and a 5-floor instance with hand-computed expectations.
module tb_elevator_ctrl_n;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] hu3, hd3, car3, lamp3;
  logic [1:0] fs3, dir3, cur3, st3;
  logic       dc3, door3;
  logic [4:0] hu5, hd5, car5, lamp5;
  logic [2:0] fs5, cur5;
  logic [1:0] dir5, st5;
  logic       dc5, door5;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  elevator_ctrl_n #(.NUM_FLOORS(3), .FS_W(2), .DWELL_CYCLES(4)) u3 (
    .clk(clk), .rst(rst), .hall_up(hu3), .hall_dn(hd3), .car(car3), .fs(fs3), .dc(dc3),
    .door(door3), .dir(dir3), .cur_floor(cur3), .state(st3), .req_lamp(lamp3)
  );

  elevator_ctrl_n #(.NUM_FLOORS(5), .FS_W(3), .DWELL_CYCLES(4)) u5 (
    .clk(clk), .rst(rst), .hall_up(hu5), .hall_dn(hd5), .car(car5), .fs(fs5), .dc(dc5),
    .door(door5), .dir(dir5), .cur_floor(cur5), .state(st5), .req_lamp(lamp5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [1:0] s, input logic d,
                      input logic [1:0] dr, input logic [1:0] c);
    chk({tag, ".state"}, 32'(st3), 32'(s));
    chk({tag, ".door"},  32'(door3), 32'(d));
    chk({tag, ".dir"},   32'(dir3), 32'(dr));
    chk({tag, ".floor"}, 32'(cur3), 32'(c));
  endtask

  task automatic chk5(input string tag, input logic [1:0] s, input logic d,
                      input logic [1:0] dr, input logic [2:0] c);
    chk({tag, ".state"}, 32'(st5), 32'(s));
    chk({tag, ".door"},  32'(door5), 32'(d));
    chk({tag, ".dir"},   32'(dir5), 32'(dr));
    chk({tag, ".floor"}, 32'(cur5), 32'(c));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    hu3 = '0; hd3 = '0; car3 = '0; fs3 = '0; dc3 = 1'b0;
    hu5 = '0; hd5 = '0; car5 = '0; fs5 = '0; dc5 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk3("rst", 2'b00, 1'b1, 2'b00, 2'd1);
    chk("rst.lamp", 32'(lamp3), 32'h0);

    // Floor 1 -> floor 2
    hu3 = 3'b001; tick(); hu3 = '0;
    chk3("t1.open", 2'b01, 1'b0, 2'b00, 2'd1);
    chk("t1.open.lamp", 32'(lamp3), 32'h0);
    car3 = 3'b010; tick(); car3 = '0;
    chk3("t1.close", 2'b00, 1'b1, 2'b00, 2'd1);
    chk("t1.close.lamp", 32'(lamp3), 32'h2);
    dc3 = 1'b1; tick(); dc3 = 1'b0;
    chk3("t1.up", 2'b10, 1'b1, 2'b01, 2'd1);
    tick();
    chk3("t1.between", 2'b10, 1'b1, 2'b01, 2'd1);
    fs3 = 2'd2; tick(); fs3 = '0;
    chk3("t1.arrive", 2'b01, 1'b0, 2'b00, 2'd2);
    chk("t1.arrive.lamp", 32'(lamp3), 32'h0);

    // Floor 2 -> top floor, then back down to 2
    car3 = 3'b100; tick(); car3 = '0;
    chk3("t2.close", 2'b00, 1'b1, 2'b00, 2'd2);
    dc3 = 1'b1; tick(); dc3 = 1'b0;
    chk3("t2.up", 2'b10, 1'b1, 2'b01, 2'd2);
    fs3 = 2'd3; tick(); fs3 = '0;
    chk3("t2.top", 2'b01, 1'b0, 2'b00, 2'd3);
    hd3 = 3'b010; tick(); hd3 = '0;
    chk3("t2.close2", 2'b00, 1'b1, 2'b00, 2'd3);
    dc3 = 1'b1; tick(); dc3 = 1'b0;
    chk3("t2.dn", 2'b11, 1'b1, 2'b10, 2'd3);
    fs3 = 2'd2; tick(); fs3 = '0;
    chk3("t2.arrive", 2'b01, 1'b0, 2'b00, 2'd2);
    chk("t2.arrive.lamp", 32'(lamp3), 32'h0);

    // Reopen from CLOSING at floor 2, with and without dc
    car3 = 3'b100; tick(); car3 = '0;
    chk3("t4.close", 2'b00, 1'b1, 2'b00, 2'd2);
    car3 = 3'b010; tick(); car3 = '0;
    chk3("t4.reopen", 2'b01, 1'b0, 2'b00, 2'd2);
    chk("t4.reopen.lamp", 32'(lamp3), 32'h4);
    tick();
    chk3("t4.reclose", 2'b00, 1'b1, 2'b00, 2'd2);
    car3 = 3'b010; dc3 = 1'b1; tick(); car3 = '0;
    chk3("t4.reopen_dc", 2'b01, 1'b0, 2'b00, 2'd2);
    tick();
    chk3("t4.close_dc", 2'b00, 1'b1, 2'b00, 2'd2);
    tick(); dc3 = 1'b0;
    chk3("t4.up", 2'b10, 1'b1, 2'b01, 2'd2);

    // Reset while moving
    chk("t5.pre.lamp", 32'(lamp3), 32'h4);
    rst = 1'b1; tick(); rst = 1'b0;
    chk3("t5.rst", 2'b00, 1'b1, 2'b00, 2'd1);
    chk("t5.rst.lamp", 32'(lamp3), 32'h0);

    // Door dwell with no further calls
    hu3 = 3'b001; tick(); hu3 = '0;
    chk3("t6.open", 2'b01, 1'b0, 2'b00, 2'd1);
`ifdef DOOR_TIMEOUT_EN
    repeat (3) tick();
    chk3("t6.dwell3", 2'b01, 1'b0, 2'b00, 2'd1);
    tick();
    chk3("t6.timeout", 2'b00, 1'b1, 2'b00, 2'd1);
`else
    repeat (100) tick();
    chk3("t6.hold", 2'b01, 1'b0, 2'b00, 2'd1);
`endif

    // 5 floors: collective up run with an intermediate stop
    car5 = 5'b10000; hu5 = 5'b00100; hd5 = 5'b01000; tick();
    car5 = '0; hu5 = '0; hd5 = '0;
    chk5("t3.latch", 2'b00, 1'b1, 2'b00, 3'd1);
    chk("t3.latch.lamp", 32'(lamp5), 32'h1C);
    dc5 = 1'b1; tick(); dc5 = 1'b0;
    chk5("t3.up", 2'b10, 1'b1, 2'b01, 3'd1);
    fs5 = 3'd7; tick();
    chk5("t3.badfs", 2'b10, 1'b1, 2'b01, 3'd1);
    fs5 = 3'd2; tick();
    chk5("t3.pass2", 2'b10, 1'b1, 2'b01, 3'd2);
    fs5 = 3'd3; tick(); fs5 = '0;
    chk5("t3.stop3", 2'b01, 1'b0, 2'b00, 3'd3);
    chk("t3.stop3.lamp", 32'(lamp5), 32'h18);
    tick();
    chk5("t3.close", 2'b00, 1'b1, 2'b00, 3'd3);
    dc5 = 1'b1; tick(); dc5 = 1'b0;
    chk5("t3.resume", 2'b10, 1'b1, 2'b01, 3'd3);
    fs5 = 3'd4; tick();
    chk5("t3.pass4", 2'b10, 1'b1, 2'b01, 3'd4);
    fs5 = 3'd5; tick(); fs5 = '0;
    chk5("t3.top", 2'b01, 1'b0, 2'b00, 3'd5);
    chk("t3.top.lamp", 32'(lamp5), 32'h08);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
